// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I funct3 size/sign codes and the full-word byte-enable mask.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the execute-side request, data-memory handshake and load/status
// result signals. Suffixes _i/_o are named from the load/store unit's side.
interface load_store_unit_if;

    // execute-side request
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;

    // data-memory handshake
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    // load result and status
    logic [31:0] ld_data_o;
    logic [4:0]  ld_rd_o;
    logic        ld_wen_o;
    logic        st_done_o;
    logic        misalign_o;
    logic        busy_o;

    // the load/store unit itself
    modport master (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output ld_data_o, ld_rd_o, ld_wen_o, st_done_o, misalign_o, busy_o
    );

    // execute stage / memory / register file around it
    modport slave (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  ld_data_o, ld_rd_o, ld_wen_o, st_done_o, misalign_o, busy_o
    );

endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane logic for the load/store unit: byte enables, store-lane
// replication, load extraction with sign/zero extension, and the legality
// check for the funct3/alignment combination.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_st_data,
    output logic [31:0] o_ld_data,
    output logic        o_illegal
);

    logic [31:0] w_shifted;
    logic        w_bad_f3;
    logic        w_bad_align;

    // the addressed byte/half moves down to bit 0 before extension
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // byte enables and store lanes follow the access size (funct3[1:0])
    always_comb begin
        o_be      = BE_WORD;
        o_st_data = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be      = 4'b0001 << i_addr_lo;
                o_st_data = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be      = 4'b0011 << i_addr_lo;
                o_st_data = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // extend the extracted field according to size and signedness
    always_comb begin
        o_ld_data = w_shifted;
        case (i_funct3)
            F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_ld_data = {24'h000000, w_shifted[7:0]};
            F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_ld_data = {16'h0000, w_shifted[15:0]};
            default: ;
        endcase
    end

    // unsupported funct3 for the direction, or a half/word off its natural boundary
    always_comb begin
        if (i_we) begin
            w_bad_f3 = !(i_funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            w_bad_f3 = !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        w_bad_align = (((i_funct3 == F3_H) || (i_funct3 == F3_HU)) && i_addr_lo[0])
                    || ((i_funct3 == F3_W) && (i_addr_lo != 2'b00));
        o_illegal   = w_bad_f3 | w_bad_align;
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from execute, runs a single-outstanding
// request/grant/rvalid handshake to data memory and returns extended load data
// to the register file with a one-cycle write pulse.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk_i,
    input  logic              regrst_i,
    load_store_unit_if.master bus
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;

    // captured request fields needed after IDLE
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_rd;

    // registered outputs
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_ld_data;
    logic [4:0]  r_ld_rd;
    logic        r_ld_wen;
    logic        r_misalign;

    logic        w_idle;
    logic        w_accept;
    logic        w_grant;
    logic        w_rvalid;
    logic        w_we;
    logic [2:0]  w_funct3;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;
    logic        w_illegal;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = bus.req_valid_i & w_idle;
    assign w_grant  = (r_state == REQ)  & bus.mem_gnt_i;
    assign w_rvalid = (r_state == WAIT) & bus.mem_rvalid_i;

    // In IDLE the aligner looks at the incoming request (for legality, mask and
    // lanes); once busy it looks at the captured one (for load extraction).
    assign w_we      = w_idle ? bus.req_we_i         : r_we;
    assign w_funct3  = w_idle ? bus.req_funct3_i     : r_funct3;
    assign w_addr_lo = w_idle ? bus.req_addr_i[1:0]  : r_addr_lo;

    lsu_data_align u_align (
        .i_funct3  (w_funct3),
        .i_we      (w_we),
        .i_addr_lo (w_addr_lo),
        .i_wdata   (bus.req_wdata_i),
        .i_rdata   (bus.mem_rdata_i),
        .o_be      (w_be),
        .o_st_data (w_st_data),
        .o_ld_data (w_ld_data),
        .o_illegal (w_illegal)
    );

    // state register
    always_ff @(posedge clk_i or posedge regrst_i) begin
        if (regrst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_illegal ? ERR : REQ;
            REQ:     if (bus.mem_gnt_i) w_state_nxt = r_we ? IDLE : WAIT;
            WAIT:    if (bus.mem_rvalid_i) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // capture the accepted request
    always_ff @(posedge clk_i or posedge regrst_i) begin
        if (regrst_i) begin
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_rd      <= 5'd0;
        end else if (w_accept) begin
            r_we      <= bus.req_we_i;
            r_funct3  <= bus.req_funct3_i;
            r_addr_lo <= bus.req_addr_i[1:0];
            r_rd      <= bus.req_rd_i;
        end
    end

    // memory request, load result and error pulse registers
    always_ff @(posedge clk_i or posedge regrst_i) begin
        if (regrst_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_ld_data   <= 32'h0;
            r_ld_rd     <= 5'd0;
            r_ld_wen    <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_ld_wen   <= 1'b0;
            r_misalign <= 1'b0;
            if (w_accept) begin
                if (w_illegal) begin
                    r_misalign <= 1'b1;
                end else begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= bus.req_we_i;
                    r_mem_addr  <= {bus.req_addr_i[31:2], 2'b00};
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_st_data;
                end
            end
            if (w_grant) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end
            if (w_rvalid) begin
                r_ld_data <= w_ld_data;
                r_ld_rd   <= r_rd;
                r_ld_wen  <= 1'b1;
            end
        end
    end

    assign bus.req_ready_o = w_idle;
    assign bus.busy_o      = !w_idle;
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_be_o    = r_mem_be;
    assign bus.mem_wdata_o = r_mem_wdata;
    assign bus.ld_data_o   = r_ld_data;
    assign bus.ld_rd_o     = r_ld_rd;
    assign bus.ld_wen_o    = r_ld_wen;
    assign bus.misalign_o  = r_misalign;
    // Store completion coincides with the grant cycle: a decode of the
    // registered REQ state and direction, qualified by the grant itself.
    assign bus.st_done_o   = w_grant & r_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a transaction-level reference model
// derives per-cycle expectations from the access rules and handshake timing.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk_i    (clk),
        .regrst_i (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // per-cycle expectations
    logic        exp_ready, exp_req, exp_we, exp_st, exp_ldwen, exp_mis;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_be;
    logic [4:0]  exp_rd;

    // cumulative pulse/level counters and observed values
    int          cnt_req = 0, cnt_st = 0, cnt_ld = 0, cnt_mis = 0;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_be;
    logic [4:0]  obs_rd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic legal_op(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        return (int'(off) % size_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] off);
        int nb;
        nb = size_bytes(f3);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] lanes_of(input logic [2:0] f3, input logic [31:0] w);
        case (size_bytes(f3))
            1:       return 32'(w[7:0]) * 32'h01010101;
            2:       return 32'(w[15:0]) * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ld_of(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        int nb;
        logic [31:0] v, mask;
        nb = size_bytes(f3);
        v  = rd >> (8 * off);
        if (nb >= 4) return v;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- per-cycle comparison ----------------
    task automatic cmp_cycle();
        check("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
        check("busy",      32'(bus.busy_o),      32'(!exp_ready));
        check("mem_req",   32'(bus.mem_req_o),   32'(exp_req));
        check("mem_we",    32'(bus.mem_we_o),    32'(exp_we));
        check("st_done",   32'(bus.st_done_o),   32'(exp_st));
        check("ld_wen",    32'(bus.ld_wen_o),    32'(exp_ldwen));
        check("misalign",  32'(bus.misalign_o),  32'(exp_mis));
        if (exp_req) begin
            check("mem_addr", bus.mem_addr_o, exp_addr);
            check("mem_be",   32'(bus.mem_be_o), 32'(exp_be));
            if (exp_we) check("mem_wdata", bus.mem_wdata_o, exp_wdata);
        end
        if (exp_ldwen) begin
            check("ld_data", bus.ld_data_o, exp_ld);
            check("ld_rd",   32'(bus.ld_rd_o), 32'(exp_rd));
        end
        cnt_req += int'(bus.mem_req_o);
        cnt_st  += int'(bus.st_done_o);
        cnt_ld  += int'(bus.ld_wen_o);
        cnt_mis += int'(bus.misalign_o);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},  32'(bus.req_ready_o), 32'd1);
        check({tag, "_busy"},   32'(bus.busy_o),      32'd0);
        check({tag, "_req"},    32'(bus.mem_req_o),   32'd0);
        check({tag, "_we"},     32'(bus.mem_we_o),    32'd0);
        check({tag, "_addr"},   bus.mem_addr_o,       32'd0);
        check({tag, "_be"},     32'(bus.mem_be_o),    32'd0);
        check({tag, "_wdata"},  bus.mem_wdata_o,      32'd0);
        check({tag, "_ldata"},  bus.ld_data_o,        32'd0);
        check({tag, "_ldrd"},   32'(bus.ld_rd_o),     32'd0);
        check({tag, "_ldwen"},  32'(bus.ld_wen_o),    32'd0);
        check({tag, "_stdone"}, 32'(bus.st_done_o),   32'd0);
        check({tag, "_mis"},    32'(bus.misalign_o),  32'd0);
    endtask

    task automatic rand_fields();
        bus.req_we_i     = 1'($urandom);
        bus.req_funct3_i = 3'($urandom);
        bus.req_addr_i   = $urandom;
        bus.req_wdata_i  = $urandom;
        bus.req_rd_i     = 5'($urandom);
    endtask

    // One transaction from accept (cycle 0) until the unit is idle again.
    // Grant arrives g cycles after the request rises, rvalid r cycles after WAIT entry.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input int g, input int r, input logic [31:0] rdata);
        logic legal;
        int   len;
        legal     = legal_op(we, f3, addr[1:0]);
        exp_addr  = {addr[31:2], 2'b00};
        exp_be    = be_of(f3, addr[1:0]);
        exp_wdata = lanes_of(f3, wdata);
        exp_ld    = ld_of(f3, addr[1:0], rdata);
        exp_rd    = rd;
        len = !legal ? 2 : (we ? 2 + g : 4 + g + r);
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.req_valid_i  = 1'b1;
                bus.req_we_i     = we;
                bus.req_funct3_i = f3;
                bus.req_addr_i   = addr;
                bus.req_wdata_i  = wdata;
                bus.req_rd_i     = rd;
            end else begin
                bus.req_valid_i = 1'($urandom);
                rand_fields();
            end
            if (legal && c >= 1 && c <= 1 + g) bus.mem_gnt_i = (c == 1 + g);
            else                                bus.mem_gnt_i = 1'($urandom);
            if (legal && !we && c >= 2 + g && c <= 2 + g + r) bus.mem_rvalid_i = (c == 2 + g + r);
            else                                               bus.mem_rvalid_i = 1'($urandom);
            bus.mem_rdata_i = (legal && !we && c == 2 + g + r) ? rdata : $urandom;
            exp_ready = (c == 0);
            exp_req   = legal && c >= 1 && c <= 1 + g;
            exp_we    = exp_req && we;
            exp_st    = legal && we && c == 1 + g;
            exp_ldwen = legal && !we && c == 3 + g + r;
            exp_mis   = !legal && c == 1;
            @(negedge clk);
            cmp_cycle();
            if (c == 1) begin
                obs_addr  = bus.mem_addr_o;
                obs_be    = bus.mem_be_o;
                obs_wdata = bus.mem_wdata_o;
            end
            if (exp_ldwen) begin
                obs_ld = bus.ld_data_o;
                obs_rd = bus.ld_rd_o;
            end
        end
    endtask

    // Idle cycles with rvalid forced high and random grants: nothing may happen.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            bus.req_valid_i  = 1'b0;
            rand_fields();
            bus.mem_gnt_i    = 1'($urandom);
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = $urandom;
            exp_ready = 1'b1;
            exp_req   = 1'b0;
            exp_we    = 1'b0;
            exp_st    = 1'b0;
            exp_ldwen = 1'b0;
            exp_mis   = 1'b0;
            @(negedge clk);
            cmp_cycle();
        end
    endtask

    initial begin
        int s0, l0, m0, q0;
        logic       rwe;
        logic [2:0] rf3;

        rst = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;
        bus.req_rd_i     = 5'd0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        #12;
        check_reset("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // SB 0xA5 to 0x1003, grant in the first request cycle
        s0 = cnt_st;
        run_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0, 0, 0, 32'h0);
        check("sb_be",    32'(obs_be), 32'h8);
        check("sb_wdata", obs_wdata,   32'hA5A5_A5A5);
        check("sb_addr",  obs_addr,    32'h0000_1000);
        check("sb_done_pulses", 32'(cnt_st - s0), 32'd1);

        // LB / LBU at 0x2002 with rdata 0x12F45678
        l0 = cnt_ld;
        run_txn(1'b0, 3'b000, 32'h0000_2002, 32'h0, 5'd7, 0, 0, 32'h12F4_5678);
        check("lb_data", obs_ld, 32'hFFFF_FFF4);
        check("lb_rd",   32'(obs_rd), 32'd7);
        check("lb_wen_pulses", 32'(cnt_ld - l0), 32'd1);
        run_txn(1'b0, 3'b100, 32'h0000_2002, 32'h0, 5'd7, 0, 0, 32'h12F4_5678);
        check("lbu_data", obs_ld, 32'h0000_00F4);

        // LH at an odd address
        m0 = cnt_mis;
        q0 = cnt_req;
        run_txn(1'b0, 3'b001, 32'h0000_3001, 32'h0, 5'd3, 0, 0, 32'h0);
        check("lh_mis_pulses", 32'(cnt_mis - m0), 32'd1);
        check("lh_mis_no_req", 32'(cnt_req - q0), 32'd0);
        idle(1);

        // LW with grant 3 cycles late and rvalid 2 more, then spurious rvalid in IDLE
        q0 = cnt_req;
        l0 = cnt_ld;
        run_txn(1'b0, 3'b010, 32'h0000_7008, 32'h0, 5'd12, 3, 2, 32'hCAFE_BABE);
        check("lw_req_cycles", 32'(cnt_req - q0), 32'd4);
        check("lw_wen_pulses", 32'(cnt_ld - l0), 32'd1);
        check("lw_data", obs_ld, 32'hCAFE_BABE);
        idle(3);

        // store aborted by reset while requesting: done pulse and request drop at once
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_funct3_i = 3'b010;
        bus.req_addr_i = 32'h0000_6000; bus.req_wdata_i = 32'h1234_5678;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0; bus.mem_gnt_i = 1'b1;
        #1;
        check("abort_st_pre_done", 32'(bus.st_done_o), 32'd1);
        check("abort_st_pre_req",  32'(bus.mem_req_o), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("abort_st");
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_gnt_i = 1'b0;

        // load aborted by reset in WAIT; rvalid after release must be ignored
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'b010;
        bus.req_addr_i = 32'h0000_5004; bus.req_rd_i = 5'd9;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0; bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b0;
        #1;
        check("abort_ld_busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("abort_ld");
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b0;
        #1;
        check_reset("after_abort");
        idle(2);
        l0 = cnt_ld;
        run_txn(1'b0, 3'b010, 32'h0000_5004, 32'h0, 5'd9, 0, 1, 32'h0BAD_F00D);
        check("post_abort_data", obs_ld, 32'h0BAD_F00D);
        check("post_abort_pulses", 32'(cnt_ld - l0), 32'd1);

        // LHU / LH at 0x4002 with rdata 0x8001FFFF
        run_txn(1'b0, 3'b101, 32'h0000_4002, 32'h0, 5'd4, 1, 0, 32'h8001_FFFF);
        check("lhu_data", obs_ld, 32'h0000_8001);
        run_txn(1'b0, 3'b001, 32'h0000_4002, 32'h0, 5'd4, 0, 1, 32'h8001_FFFF);
        check("lh_data", obs_ld, 32'hFFFF_8001);

        // randomized traffic
        for (int t = 0; t < 250; t++) begin
            rwe = 1'($urandom);
            rf3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                  (rwe ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            run_txn(rwe, rf3, $urandom, $urandom, 5'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 4) == 0) idle(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
